// File: rtl/acc_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acc_cpu_sequencer
// Description : Multi-cycle control unit for a 4-bit accumulator CPU.
//               Fetches 8-bit instructions ({opcode, imm}) over a req/valid
//               handshake, holds PC / IR / ACC / zero flag, drives an
//               external combinational ALU and sequences
//               IDLE -> FETCH -> DECODE -> EXECUTE -> (FETCH | HALT).
// Ports       : clk, rst          - clock (rising edge), sync active-high reset
//               start             - leave IDLE and begin fetching at PC
//               imem_addr/req     - instruction address (= PC), fetch request
//               imem_data/valid   - returned instruction, valid qualifier
//               alu_acc/imm/opcode- ALU operands (ACC, IR[3:0], IR[7:4])
//               alu_result        - ALU combinational result
//               acc, zero         - accumulator and zero flag
//               out_data/valid    - output-port register and write pulse
//               busy, halted      - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module acc_cpu_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [7:0]        imem_data,
    input  logic              imem_valid,
    output logic [3:0]        alu_acc,
    output logic [3:0]        alu_imm,
    output logic [3:0]        alu_opcode,
    input  logic [3:0]        alu_result,
    output logic [3:0]        acc,
    output logic              zero,
    output logic [3:0]        out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        ir_q;
    logic [3:0]        acc_q;
    logic              zero_q;
    logic [3:0]        out_data_q;
    logic              out_valid_q;
    logic              imem_req_q;
    logic              busy_q;
    logic              halted_q;

    logic [3:0]        w_op;
    logic [3:0]        w_imm;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_imm;
    logic              w_fetch_done;

    assign w_op         = ir_q[7:4];
    assign w_imm        = ir_q[3:0];
    assign w_pc_inc     = pc_q + ADDR_W'(1);
    assign w_pc_imm     = ADDR_W'(w_imm);
    // imem_req_q is high exactly in FETCH, so valid is only honoured there.
    assign w_fetch_done = imem_req_q && imem_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH:   if (w_fetch_done) state_d = S_DECODE;
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = (w_op == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            acc_q       <= '0;
            zero_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            imem_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Status outputs are registered from the next state so they line
            // up with state_q in every cycle.
            imem_req_q  <= (state_d == S_FETCH);
            busy_q      <= (state_d == S_FETCH) || (state_d == S_DECODE) ||
                           (state_d == S_EXECUTE);
            halted_q    <= (state_d == S_HALT);
            out_valid_q <= 1'b0;

            if (state_q == S_FETCH && w_fetch_done) begin
                ir_q <= imem_data;
            end

            if (state_q == S_EXECUTE) begin
                case (w_op)
                    OP_LDI: begin
                        acc_q  <= w_imm;
                        zero_q <= (w_imm == 4'h0);
                        pc_q   <= w_pc_inc;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        acc_q  <= alu_result;
                        zero_q <= (alu_result == 4'h0);
                        pc_q   <= w_pc_inc;
                    end
                    OP_JMP: pc_q <= w_pc_imm;
                    // zero_q still holds the flag from before this instruction.
                    OP_JZ:  pc_q <= zero_q ? w_pc_imm : w_pc_inc;
                    OP_OUT: begin
                        out_data_q  <= acc_q;
                        out_valid_q <= 1'b1;
                        pc_q        <= w_pc_inc;
                    end
                    OP_HLT: pc_q <= pc_q;
                    default: pc_q <= w_pc_inc;   // NOP and 0x9-0xE
                endcase
            end
        end
    end

    assign imem_addr  = pc_q;
    assign imem_req   = imem_req_q;
    assign alu_acc    = acc_q;
    assign alu_imm    = w_imm;
    assign alu_opcode = w_op;
    assign acc        = acc_q;
    assign zero       = zero_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_cpu_sequencer
// Description : Self-checking bench for acc_cpu_sequencer. Provides an
//               instruction memory with programmable wait states and the
//               external ALU, applies a table of single-instruction vectors
//               and several hand-written programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] imem_addr;
    logic       imem_req;
    logic [7:0] imem_data;
    logic       imem_valid;
    logic [3:0] alu_acc, alu_imm, alu_opcode, alu_result;
    logic [3:0] acc;
    logic       zero;
    logic [3:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       halted;

    always #5 clk = ~clk;

    acc_cpu_sequencer #(.ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .alu_acc    (alu_acc),
        .alu_imm    (alu_imm),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .acc        (acc),
        .zero       (zero),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .halted     (halted)
    );

    // ---------------- instruction memory with wait states ----------------
    logic [7:0] mem [16];
    int         wait_n = 0;
    int         wcnt = 0;
    logic       force_valid = 1'b0;

    assign imem_data  = mem[imem_addr];
    assign imem_valid = (imem_req && (wcnt == wait_n)) || force_valid;

    always @(posedge clk) begin
        if (imem_req && !imem_valid) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
    end

    // ---------------- external ALU ----------------
    always_comb begin
        alu_result = 4'h0;
        case (alu_opcode)
            4'h2: alu_result = alu_acc + alu_imm;
            4'h3: alu_result = alu_acc - alu_imm;
            4'h4: alu_result = alu_acc & alu_imm;
            4'h5: alu_result = alu_acc | alu_imm;
            default: alu_result = 4'h0;
        endcase
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    int         entry_cyc [$];
    logic [3:0] entry_addr [$];
    int         ov_cnt;
    logic [3:0] ov_data;
    int         unstable;
    bit         halted_seen;

    // Starts the CPU and observes it once per cycle until HALT or maxc cycles.
    task automatic run_prog(input int maxc, input bit hold_start);
        bit         prev_req;
        logic [3:0] cur_addr;
        entry_cyc.delete();
        entry_addr.delete();
        ov_cnt = 0;
        ov_data = 4'h0;
        unstable = 0;
        halted_seen = 0;
        prev_req = 1'b0;
        cur_addr = 4'h0;
        start = 1'b1;
        tick();
        start = hold_start;
        for (int c = 0; c < maxc; c++) begin
            if (imem_req && !prev_req) begin
                entry_cyc.push_back(c);
                entry_addr.push_back(imem_addr);
                cur_addr = imem_addr;
            end else if (imem_req && (imem_addr !== cur_addr)) begin
                unstable++;
            end
            if (out_valid) begin
                ov_cnt++;
                ov_data = out_data;
            end
            prev_req = imem_req;
            if (halted) begin
                halted_seen = 1;
                break;
            end
            tick();
        end
        start = 1'b0;
    endtask

    // ---------------- single-instruction vectors ----------------
    // mem[0] = LDI pre, mem[1] = ins, all other words HLT.
    typedef struct {
        string      name;
        logic [3:0] pre;
        logic [7:0] ins;
        logic [3:0] e_acc;
        logic       e_zero;
        logic [3:0] e_pc;
        int         e_ov;
        logic [3:0] e_out;
    } vec_t;

    vec_t vecs [12];

    task automatic check_arith_prog(input string tag, input int period);
        chk({tag, "_halted"}, halted_seen, 1);
        chk({tag, "_acc"}, acc, 4'h0);
        chk({tag, "_zero"}, zero, 1'b1);
        chk({tag, "_pc"}, imem_addr, 4'd4);
        chk({tag, "_ov_cnt"}, ov_cnt, 1);
        chk({tag, "_ov_data"}, ov_data, 4'h0);
        chk({tag, "_entries"}, entry_cyc.size(), 5);
        chk({tag, "_unstable"}, unstable, 0);
        for (int i = 1; i < entry_cyc.size(); i++)
            chk($sformatf("%s_period%0d", tag, i), entry_cyc[i] - entry_cyc[i-1], period);
    endtask

    initial begin
        vecs[0]  = '{"add_wrap",   4'h7, 8'h29, 4'h0, 1'b1, 4'd2, 0, 4'h0};
        vecs[1]  = '{"sub_borrow", 4'h3, 8'h35, 4'hE, 1'b0, 4'd2, 0, 4'h0};
        vecs[2]  = '{"and_zero",   4'hC, 8'h43, 4'h0, 1'b1, 4'd2, 0, 4'h0};
        vecs[3]  = '{"or",         4'h5, 8'h5A, 4'hF, 1'b0, 4'd2, 0, 4'h0};
        vecs[4]  = '{"ldi0",       4'h5, 8'h10, 4'h0, 1'b1, 4'd2, 0, 4'h0};
        vecs[5]  = '{"jz_taken",   4'h0, 8'h76, 4'h0, 1'b1, 4'd6, 0, 4'h0};
        vecs[6]  = '{"jz_not",     4'h1, 8'h76, 4'h1, 1'b0, 4'd2, 0, 4'h0};
        vecs[7]  = '{"jmp",        4'h4, 8'h69, 4'h4, 1'b0, 4'd9, 0, 4'h0};
        vecs[8]  = '{"out",        4'h9, 8'h80, 4'h9, 1'b0, 4'd2, 1, 4'h9};
        vecs[9]  = '{"nop_alias",  4'h6, 8'hB7, 4'h6, 1'b0, 4'd2, 0, 4'h0};
        vecs[10] = '{"hlt",        4'h0, 8'hF0, 4'h0, 1'b1, 4'd1, 0, 4'h0};
        vecs[11] = '{"sub_zero",   4'h2, 8'h32, 4'h0, 1'b1, 4'd2, 0, 4'h0};

        rst = 1'b1;
        start = 1'b0;
        fill_mem(8'hF0);

        // ---- reset state ----
        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_pc", imem_addr, 4'h0);
        chk("rst_acc", acc, 4'h0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_out", {out_valid, out_data}, 5'h0);
        chk("rst_ir", {alu_opcode, alu_imm}, 8'h00);

        // ---- table of single-instruction vectors ----
        foreach (vecs[k]) begin
            do_reset();
            fill_mem(8'hF0);
            mem[0] = {4'h1, vecs[k].pre};
            mem[1] = vecs[k].ins;
            run_prog(40, 1'b0);
            chk({vecs[k].name, "_halted"}, halted_seen, 1);
            chk({vecs[k].name, "_acc"}, acc, vecs[k].e_acc);
            chk({vecs[k].name, "_zero"}, zero, vecs[k].e_zero);
            chk({vecs[k].name, "_pc"}, imem_addr, vecs[k].e_pc);
            chk({vecs[k].name, "_ov_cnt"}, ov_cnt, vecs[k].e_ov);
            chk({vecs[k].name, "_out"}, out_data, vecs[k].e_out);
        end

        // ---- reset mid-FETCH with imem_valid on the same edge ----
        do_reset();
        fill_mem(8'hF0);
        mem[0] = 8'h17;
        mem[1] = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && imem_addr == 4'd1) break;
            tick();
        end
        chk("midrst_in_fetch", {imem_req, imem_addr, acc}, {1'b1, 4'd1, 4'h7});
        force_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_req", imem_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_pc", imem_addr, 4'h0);
        chk("midrst_acc", acc, 4'h0);
        chk("midrst_zero", zero, 1'b0);
        chk("midrst_ir", {alu_opcode, alu_imm}, 8'h00);
        tick();
        tick();
        tick();
        chk("midrst_idle_req", {imem_req, busy}, 2'b00);
        chk("midrst_idle_ir", {alu_opcode, alu_imm}, 8'h00);
        force_valid = 1'b0;
        run_prog(40, 1'b0);
        chk("midrst_restart_acc", {halted_seen, acc, imem_addr}, {1'b1, 4'h7, 4'd2});

        // ---- arithmetic program, zero-wait ----
        do_reset();
        fill_mem(8'hF0);
        mem[0] = 8'h17; mem[1] = 8'h29; mem[2] = 8'h30; mem[3] = 8'h80; mem[4] = 8'hF0;
        wait_n = 0;
        run_prog(60, 1'b0);
        check_arith_prog("arith0", 3);

        // ---- same program with 4 wait states per fetch ----
        do_reset();
        wait_n = 4;
        run_prog(100, 1'b0);
        check_arith_prog("arith4", 7);
        wait_n = 0;

        // ---- logic + JZ program ----
        do_reset();
        fill_mem(8'hF0);
        mem[0] = 8'h1C; mem[1] = 8'h43; mem[2] = 8'h75;
        mem[5] = 8'h5A; mem[6] = 8'h70; mem[7] = 8'hF0;
        run_prog(60, 1'b0);
        chk("logic_halted", halted_seen, 1);
        chk("logic_pc", imem_addr, 4'd7);
        chk("logic_acc", acc, 4'hA);
        chk("logic_zero", zero, 1'b0);
        begin
            logic [3:0] exp_addr [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7};
            chk("logic_entries", entry_addr.size(), 6);
            for (int i = 0; i < 6 && i < entry_addr.size(); i++)
                chk($sformatf("logic_addr%0d", i), entry_addr[i], exp_addr[i]);
        end

        // ---- PC wrap and undefined opcodes ----
        do_reset();
        fill_mem(8'h90);
        mem[0] = 8'h62;
        run_prog(60, 1'b0);
        begin
            logic [3:0] pc_m;
            int         bad;
            pc_m = 4'd0;
            bad = 0;
            for (int i = 0; i < entry_addr.size(); i++) begin
                if (entry_addr[i] !== pc_m) bad++;
                pc_m = (pc_m == 4'd0) ? 4'd2 : pc_m + 4'd1;
            end
            chk("wrap_entries_ge17", entry_addr.size() >= 17, 1);
            chk("wrap_addr_seq_bad", bad, 0);
        end
        chk("wrap_acc_zero", {acc, zero}, 5'h00);
        chk("wrap_not_halted", {halted_seen, busy}, 2'b01);

        // ---- start held during execution, then pulsed in HALT ----
        do_reset();
        fill_mem(8'hF0);
        mem[0] = 8'h13;
        run_prog(40, 1'b1);
        chk("hlt_halted", halted_seen, 1);
        chk("hlt_pc_acc", {imem_addr, acc}, {4'd1, 4'h3});
        start = 1'b1;
        tick();
        tick();
        tick();
        start = 1'b0;
        tick();
        chk("hlt_start_ignored", {halted, busy, imem_req}, 3'b100);
        chk("hlt_regs_hold", {imem_addr, acc, zero}, {4'd1, 4'h3, 1'b0});
        do_reset();
        chk("hlt_exit_rst", {halted, busy, imem_addr, acc}, {1'b0, 1'b0, 4'd0, 4'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_cpu_sequencer.md
Name: acc_cpu_sequencer

Overview:
- Multi-cycle control unit for the 4-bit accumulator CPU.
- Fetches 8-bit instructions over a req/valid handshake and holds the instruction register (IR), program counter (PC), accumulator (ACC) and zero flag.
- Drives the external combinational ALU: ACC and IMM in, opcode in, result out.
- Sequences FETCH -> DECODE -> EXECUTE, and handles jumps, output writes and halt.

Parameters:
- ADDR_W, 4, PC / instruction-address width. PC wraps at 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin execution from IDLE. Ignored in every other state.
- imem_addr  output  ADDR_W  instruction address. Equals PC.
- imem_req  output  1  fetch request, high only in FETCH.
- imem_data  input  8  instruction: [7:4] opcode, [3:0] imm.
- imem_valid  input  1  imem_data valid this cycle. Sampled only while imem_req=1.
- alu_acc  output  4  ACC to ALU.
- alu_imm  output  4  IR[3:0] to ALU.
- alu_opcode  output  4  IR[7:4] to ALU.
- alu_result  input  4  ALU combinational result.
- acc  output  4  accumulator register.
- zero  output  1  zero flag.
- out_data  output  4  output-port register.
- out_valid  output  1  one-cycle pulse when out_data is written.
- busy  output  1  high in FETCH, DECODE, EXECUTE.
- halted  output  1  high in HALT.

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, HALT. Every register updates only on the rising clk edge.
- Reset (rst=1 at an edge, including mid-instruction or mid-fetch):
  - state=IDLE.
  - PC, ACC, IR, zero, out_data all 0.
  - out_valid=0, imem_req=0.
  - Any in-flight fetch is abandoned. A late imem_valid is ignored because imem_req=0.
- IDLE: start=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - Stays in FETCH while imem_valid=0; wait states are unbounded.
  - imem_valid=1 -> IR<=imem_data, then DECODE.
  - Zero-wait fetch therefore takes 1 cycle.
- DECODE: 1 cycle. The ALU inputs settle (alu_* are driven from ACC and IR continuously in all states). Always -> EXECUTE.
- EXECUTE: 1 cycle. Commits according to IR[7:4]:
  - 0x0 NOP: PC<=PC+1.
  - 0x1 LDI: ACC<=imm, zero<=(imm==0), PC+1.
  - 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR: ACC<=alu_result, zero<=(alu_result==0), PC+1. Arithmetic is mod 16; no carry/borrow is kept.
  - 0x6 JMP: PC<=zero-extended imm.
  - 0x7 JZ: PC<=imm if zero=1, else PC+1. Tests the flag value before this instruction.
  - 0x8 OUT: out_data<=ACC, out_valid=1 for exactly the next cycle, PC+1.
  - 0xF HLT: PC unchanged -> HALT.
  - 0x9-0xE: treated as NOP.
  - Next state is FETCH, except HLT.
- Flags: zero is modified only by LDI, ADD, SUB, AND, OR.
- PC: +1 wraps from 2^ADDR_W-1 to 0.
- HALT: halted=1, busy=0, imem_req=0. All registers hold. start is ignored. Exit only by rst.
- Throughput: a zero-wait instruction takes 3 cycles, from FETCH entry to the next FETCH entry.
- Simultaneous events:
  - rst has priority over start and imem_valid.
  - start asserted outside IDLE has no effect.
  - imem_valid outside FETCH has no effect.
- out_valid is 0 in every cycle other than the one following an OUT EXECUTE.

Test Plan:
- Reset/idle: assert rst mid-FETCH with imem_valid=1 on the same edge -> state IDLE; PC=0, ACC=0, zero=0, imem_req=0, IR unchanged at 0; start must be re-applied.
- Arithmetic program (zero-wait memory):
  - Program: LDI 7, ADD 9, SUB 0, OUT, HLT.
  - ACC goes 7 -> 0 (16 mod 16), zero=1 after ADD; SUB 0 keeps ACC=0, zero=1.
  - out_data=0 with a one-cycle out_valid. halted=1 with PC=4.
  - Instruction boundaries are 3 cycles apart.
- Logic + JZ:
  - Program: LDI 0xC, AND 0x3 (ACC=0, zero=1), JZ 5 (taken, PC=5); at address 5: OR 0xA (ACC=0xA, zero=0); JZ 0 (not taken, PC=7); HLT at 7.
  - Final state: PC=7, ACC=0xA.
- Wait states: hold imem_valid=0 for 4 cycles per fetch -> imem_req and imem_addr stay stable throughout; instruction period is 7 cycles; results identical to the zero-wait run.
- PC wrap and undefined ops:
  - Fill addresses 0-15 with 0x9 (NOP-alias) except address 0 = JMP 2 after one pass; start at PC=0 after reset.
  - PC steps 2..15 then wraps to 0; ACC and zero unchanged throughout.
- start/HLT: pulse start during EXECUTE and during HALT -> no state change; HALT persists until rst.
